// File: rtl/txt_msg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : txt_msg_ctrl
// Brief   : Typewriter-style reveal controller for the end-of-game message
//           ROMs. It muxes up to four message ROMs onto the font ROM input and
//           reveals the selected line one character every TICKS_PER_CHAR
//           frame ticks. Unrevealed columns are forced to a blank.
// Revision: 1.0 - initial release
// ============================================================================
module txt_msg_ctrl #(
    parameter int N_MSG          = 4,
    parameter int LINE_LEN       = 16,
    parameter int TICKS_PER_CHAR = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         msg_sel,
    input  logic               frame_tick,
    input  logic [7:0]         char_xy,
    output logic [7:0]         rom_char_xy,
    input  logic [7*N_MSG-1:0] rom_codes,
    output logic [6:0]         char_code,
    output logic               busy,
    output logic               done
);

    localparam int TW = (TICKS_PER_CHAR > 1) ? $clog2(TICKS_PER_CHAR) : 1;

    localparam logic [1:0]    c_IDLE      = 2'd0;
    localparam logic [1:0]    c_REVEAL    = 2'd1;
    localparam logic [1:0]    c_HOLD      = 2'd2;
    localparam logic [6:0]    c_BLANK     = 7'h20;
    localparam logic [TW-1:0] c_TICK_LAST = TW'(TICKS_PER_CHAR - 1);
    localparam logic [4:0]    c_LINE_LEN  = 5'(LINE_LEN);

    logic [1:0]    state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [4:0]    shown_q, shown_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          vis_q, vis_d;
    logic [6:0]    char_code_q, char_code_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [1:0]    w_sel_clamped;
    logic [6:0]    w_lane [0:3];

    // All message ROMs share the renderer address; the ROMs add one cycle.
    assign rom_char_xy = char_xy;

    // Spread the packed ROM bus into four lanes; absent lanes read as blank so
    // a 2-bit select can index the array without range concerns.
    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            if (k < N_MSG) begin : g_used
                assign w_lane[k] = rom_codes[7*k +: 7];
            end else begin : g_unused
                assign w_lane[k] = c_BLANK;
            end
        end
    endgenerate

    // Out-of-range message selects fall back to message 0.
    assign w_sel_clamped = ({30'd0, msg_sel} >= 32'(N_MSG)) ? 2'd0 : msg_sel;

    // State, reveal counters and the two-stage character pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_IDLE;
            sel_q       <= 2'd0;
            shown_q     <= 5'd0;
            tick_q      <= '0;
            vis_q       <= 1'b0;
            char_code_q <= c_BLANK;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            shown_q     <= shown_d;
            tick_q      <= tick_d;
            vis_q       <= vis_d;
            char_code_q <= char_code_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state: start beats abort, and both beat a same-cycle frame tick.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        shown_d = shown_q;
        tick_d  = tick_q;
        if (start) begin
            state_d = c_REVEAL;
            sel_d   = w_sel_clamped;
            shown_d = 5'd0;
            tick_d  = '0;
        end else if (abort) begin
            state_d = c_IDLE;
            shown_d = 5'd0;
            tick_d  = '0;
        end else if ((state_q == c_REVEAL) && frame_tick) begin
            if (tick_q == c_TICK_LAST) begin
                tick_d  = '0;
                shown_d = shown_q + 5'd1;
                if ((shown_q + 5'd1) == c_LINE_LEN) begin
                    state_d = c_HOLD;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    // Outputs: visibility for the address in flight, then the lane mux one
    // cycle later when the ROM data arrives; status mirrors the next state.
    always_comb begin
        vis_d       = (state_q != c_IDLE) && ({1'b0, char_xy[3:0]} < shown_q);
        char_code_d = (vis_q && (state_d != c_IDLE)) ? w_lane[sel_q] : c_BLANK;
        busy_d      = (state_d == c_REVEAL);
        done_d      = (state_d == c_HOLD);
    end

    assign char_code = char_code_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire
